// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0]  ROM_REGION  = 4'h3;
  localparam int unsigned WORD_STRIDE = 4;

endpackage

// File: rtl/dmem_burst_gen.sv
// DMA burst address/remaining-count tracker with a registered last-beat flag.
module dmem_burst_gen
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              last_q, last_d;

  // Base is word-aligned on load; address wraps naturally at 2^ADDR_W.
  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    last_d = last_q;
    if (load_i) begin
      addr_d = base_i & ~ADDR_W'(WORD_STRIDE - 1);
      rem_d  = len_i;
      last_d = (len_i == LEN_W'(1));
    end else if (step_i) begin
      addr_d = addr_q + ADDR_W'(WORD_STRIDE);
      rem_d  = rem_q - LEN_W'(1);
      last_d = (rem_q == LEN_W'(2));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      rem_q  <= '0;
      last_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
      last_q <= last_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = last_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter: pipeline MEM stage has priority, DMA bursts fill
// idle slots, and a starvation counter forces a DMA beat after a run of pipeline wins.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned LEN_W        = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_MemRead,
  input  logic              p_MemWrite,
  input  logic [ADDR_W-1:0] p_Address,
  input  logic [DATA_W-1:0] p_WrData,
  output logic [DATA_W-1:0] p_ReadData,
  output logic              p_Stall,
  input  logic              d_Start,
  input  logic              d_Write,
  input  logic [ADDR_W-1:0] d_Base,
  input  logic [LEN_W-1:0]  d_Len,
  input  logic [DATA_W-1:0] d_WrData,
  output logic              d_Beat,
  output logic [DATA_W-1:0] d_RdData,
  output logic              d_Busy,
  output logic              d_Done,
  output logic              m_MemRead,
  output logic              m_MemWrite,
  output logic [ADDR_W-1:0] m_Address,
  output logic [DATA_W-1:0] m_WrData,
  input  logic [DATA_W-1:0] m_ReadData
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              dir_q, dir_d;
  logic              p_req;
  logic              grant_d;
  logic              load;
  logic              step;
  logic              last;
  logic [ADDR_W-1:0] dma_addr;

  assign p_req = (p_MemRead | p_MemWrite) & (p_Address[ADDR_W-1 -: 4] != ROM_REGION);

  dmem_burst_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_burst_gen (
    .clk    (clk),
    .reset  (reset),
    .load_i (load),
    .step_i (step),
    .base_i (d_Base),
    .len_i  (d_Len),
    .addr_o (dma_addr),
    .last_o (last)
  );

  // Next-state, grant decision and zero-latency RAM mux.
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    dir_d      = dir_q;
    load       = 1'b0;
    step       = 1'b0;
    grant_d    = 1'b0;
    d_Beat     = 1'b0;
    p_Stall    = 1'b0;
    d_Busy     = 1'b0;
    d_Done     = 1'b0;
    m_MemRead  = p_MemRead & p_req;
    m_MemWrite = p_MemWrite & p_req;
    m_Address  = p_Address;
    m_WrData   = p_WrData;

    unique case (state_q)
      IDLE: begin
        starve_d = '0;
        if (d_Start) begin
          if (d_Len != '0) begin
            load    = 1'b1;
            dir_d   = d_Write;
            state_d = BURST;
          end else begin
            state_d = DONE;
          end
        end
      end
      BURST: begin
        d_Busy  = 1'b1;
        grant_d = ~p_req | (starve_q == CNT_W'(STARVE_LIMIT));
        if (grant_d) begin
          step       = 1'b1;
          d_Beat     = 1'b1;
          p_Stall    = p_req;
          starve_d   = '0;
          m_MemRead  = ~dir_q;
          m_MemWrite = dir_q;
          m_Address  = dma_addr;
          m_WrData   = d_WrData;
          if (last) begin
            state_d = DONE;
          end
        end else begin
          starve_d = starve_q + CNT_W'(1);
        end
      end
      DONE: begin
        d_Done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset quiesces the RAM port in the very cycle it is asserted.
    if (reset) begin
      load       = 1'b0;
      step       = 1'b0;
      d_Beat     = 1'b0;
      p_Stall    = 1'b0;
      d_Busy     = 1'b0;
      d_Done     = 1'b0;
      m_MemRead  = 1'b0;
      m_MemWrite = 1'b0;
      m_Address  = p_Address;
      m_WrData   = p_WrData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      dir_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      dir_q    <= dir_d;
    end
  end

  assign p_ReadData = m_ReadData;
  assign d_RdData   = m_ReadData;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int LIMIT = 4;

  typedef struct {
    bit          rst;
    bit          prd;
    bit          pwr;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    bit          start;
    bit          dwrite;
    logic [31:0] dbase;
    logic [7:0]  dlen;
    logic [31:0] dwdata;
  } stim_t;

  typedef struct {
    int          cyc;
    bit          rd;
    bit          wr;
    bit          beat;
    bit          stall;
    bit          done;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_MemRead, p_MemWrite;
  logic [31:0] p_Address, p_WrData, p_ReadData;
  logic        p_Stall;
  logic        d_Start, d_Write;
  logic [31:0] d_Base;
  logic [7:0]  d_Len;
  logic [31:0] d_WrData, d_RdData;
  logic        d_Beat, d_Busy, d_Done;
  logic        m_MemRead, m_MemWrite;
  logic [31:0] m_Address, m_WrData, m_ReadData;

  stim_t stim[$];
  ev_t   exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    cur_cyc = 0;
  bit    running = 1'b0;
  bit    exp_busy = 1'b0;

  // Reference model state
  int          mmode = 0;   // 0 idle, 1 burst, 2 done
  int          mrem = 0;
  int          mwins = 0;
  logic [31:0] maddr = '0;
  bit          mdir = 1'b0;

  function automatic logic [31:0] rdfn(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  assign m_ReadData = rdfn(m_Address);

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .p_MemRead  (p_MemRead),
    .p_MemWrite (p_MemWrite),
    .p_Address  (p_Address),
    .p_WrData   (p_WrData),
    .p_ReadData (p_ReadData),
    .p_Stall    (p_Stall),
    .d_Start    (d_Start),
    .d_Write    (d_Write),
    .d_Base     (d_Base),
    .d_Len      (d_Len),
    .d_WrData   (d_WrData),
    .d_Beat     (d_Beat),
    .d_RdData   (d_RdData),
    .d_Busy     (d_Busy),
    .d_Done     (d_Done),
    .m_MemRead  (m_MemRead),
    .m_MemWrite (m_MemWrite),
    .m_Address  (m_Address),
    .m_WrData   (m_WrData),
    .m_ReadData (m_ReadData)
  );

  // pm: 0 pipeline idle, 1 RAM read, 2 ROM read, 3 random mix
  function automatic stim_t mk(input int pm);
    stim_t s;
    int    r;
    s.rst    = 1'b0;
    s.prd    = 1'b0;
    s.pwr    = 1'b0;
    s.paddr  = $urandom & 32'hFFFF_FFFC;
    s.pwdata = $urandom;
    s.start  = 1'b0;
    s.dwrite = 1'b0;
    s.dbase  = $urandom;
    s.dlen   = 8'($urandom);
    s.dwdata = $urandom;
    if (s.paddr[31:28] == 4'h3) s.paddr[31] = 1'b1;
    case (pm)
      1: s.prd = 1'b1;
      2: begin s.prd = 1'b1; s.paddr = 32'h3000_0010; end
      3: begin
        r = int'($urandom_range(0, 2));
        s.prd = (r == 1);
        s.pwr = (r == 2);
        if ($urandom_range(0, 3) == 0) s.paddr[31:28] = 4'h3;
      end
      default: ;
    endcase
    return s;
  endfunction

  task automatic push_n(input int n, input int pm);
    for (int i = 0; i < n; i++) stim.push_back(mk(pm));
  endtask

  task automatic push_start(input int pm, input bit w, input logic [31:0] b, input logic [7:0] l);
    stim_t s;
    s = mk(pm);
    s.start  = 1'b1;
    s.dwrite = w;
    s.dbase  = b;
    s.dlen   = l;
    stim.push_back(s);
  endtask

  task automatic push_rst(input int n, input int pm);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      s = mk(pm);
      s.rst = 1'b1;
      stim.push_back(s);
    end
  endtask

  // Behavioural model: one call per issued cycle, pushes the RAM-port event expected then.
  task automatic model_step(input stim_t s, input int c);
    bit  preq;
    ev_t e;
    preq     = (s.prd || s.pwr) && (s.paddr[31:28] != 4'h3);
    exp_busy = !s.rst && (mmode == 1);
    e.cyc   = c;
    e.rd    = s.prd && preq;
    e.wr    = s.pwr && preq;
    e.beat  = 1'b0;
    e.stall = 1'b0;
    e.done  = 1'b0;
    e.addr  = s.paddr;
    e.data  = s.pwdata;
    if (s.rst) begin
      mmode = 0;
      mwins = 0;
    end else if (mmode == 0) begin
      if (preq) exp_q.push_back(e);
      if (s.start) begin
        if (s.dlen != 0) begin
          mmode = 1;
          mrem  = int'(s.dlen);
          maddr = {s.dbase[31:2], 2'b00};
          mdir  = s.dwrite;
          mwins = 0;
        end else begin
          mmode = 2;
        end
      end
    end else if (mmode == 1) begin
      if (!preq || mwins == LIMIT) begin
        e.beat  = 1'b1;
        e.stall = preq;
        e.rd    = !mdir;
        e.wr    = mdir;
        e.addr  = maddr;
        e.data  = s.dwdata;
        exp_q.push_back(e);
        maddr = maddr + 32'd4;
        mrem  = mrem - 1;
        mwins = 0;
        if (mrem == 0) mmode = 2;
      end else begin
        exp_q.push_back(e);
        mwins = mwins + 1;
      end
    end else begin
      e.done = 1'b1;
      exp_q.push_back(e);
      mmode = 0;
    end
  endtask

  // Monitor: samples on the falling edge, pops an expectation whenever the port is active.
  always @(negedge clk) begin
    ev_t e;
    bit  bad;
    if (running) begin
      tests = tests + 1;
      if (d_Busy !== exp_busy) begin
        fails = fails + 1;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cur_cyc, d_Busy, exp_busy);
      end
      if (m_MemRead || m_MemWrite || d_Done || p_Stall || d_Beat) begin
        tests = tests + 1;
        if (exp_q.size() == 0) begin
          fails = fails + 1;
          $display("FAIL event cyc=%0d unexpected: rd=%b wr=%b addr=%h beat=%b stall=%b done=%b",
                   cur_cyc, m_MemRead, m_MemWrite, m_Address, d_Beat, p_Stall, d_Done);
        end else begin
          e = exp_q.pop_front();
          bad = (e.cyc != cur_cyc) || (m_MemRead !== e.rd) || (m_MemWrite !== e.wr) ||
                (m_Address !== e.addr) || (m_WrData !== e.data) || (d_Beat !== e.beat) ||
                (p_Stall !== e.stall) || (d_Done !== e.done);
          if (!bad && e.rd) bad = e.beat ? (d_RdData !== rdfn(e.addr)) : (p_ReadData !== rdfn(e.addr));
          if (bad) begin
            fails = fails + 1;
            $display("FAIL event cyc=%0d got rd=%b wr=%b addr=%h wd=%h beat=%b stall=%b done=%b | exp cyc=%0d rd=%b wr=%b addr=%h wd=%h beat=%b stall=%b done=%b",
                     cur_cyc, m_MemRead, m_MemWrite, m_Address, m_WrData, d_Beat, p_Stall, d_Done,
                     e.cyc, e.rd, e.wr, e.addr, e.data, e.beat, e.stall, e.done);
          end
        end
      end
    end
  end

  initial begin
    stim_t s;
    reset = 1'b1;
    p_MemRead = 1'b0; p_MemWrite = 1'b0; p_Address = '0; p_WrData = '0;
    d_Start = 1'b0; d_Write = 1'b0; d_Base = '0; d_Len = '0; d_WrData = '0;

    push_rst(3, 1);
    push_n(2, 0);
    push_start(0, 1'b1, 32'h0000_0100, 8'd3);
    push_n(6, 0);
    push_start(1, 1'b0, 32'h0000_0200, 8'd2);
    push_n(14, 1);
    push_n(2, 0);
    push_start(2, 1'b0, 32'h0000_0400, 8'd4);
    push_n(7, 2);
    push_start(0, 1'b0, 32'h0000_0500, 8'd0);
    push_start(0, 1'b1, 32'h0000_0A00, 8'd3);
    push_n(3, 0);
    push_start(0, 1'b1, 32'h0000_0600, 8'd5);
    push_start(0, 1'b0, 32'h0000_0900, 8'd7);
    push_start(3, 1'b0, 32'h0000_0900, 8'd7);
    push_n(6, 0);
    push_start(0, 1'b1, 32'hFFFF_FFFC, 8'd2);
    push_n(4, 0);
    push_start(0, 1'b0, 32'h0000_0103, 8'd1);
    push_n(3, 0);
    push_start(0, 1'b1, 32'h0000_0700, 8'd8);
    push_n(3, 3);
    push_rst(2, 3);
    push_n(4, 0);
    for (int i = 0; i < 500; i++) begin
      s = mk(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 7) == 0) begin
        s.start  = 1'b1;
        s.dwrite = 1'($urandom);
        s.dlen   = 8'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 149) == 0) s.rst = 1'b1;
      stim.push_back(s);
    end
    push_n(10, 0);

    for (int c = 0; c < stim.size(); c++) begin
      @(posedge clk);
      #1;
      s = stim[c];
      reset      = s.rst;
      p_MemRead  = s.prd;
      p_MemWrite = s.pwr;
      p_Address  = s.paddr;
      p_WrData   = s.pwdata;
      d_Start    = s.start;
      d_Write    = s.dwrite;
      d_Base     = s.dbase;
      d_Len      = s.dlen;
      d_WrData   = s.dwdata;
      model_step(s, c);
      cur_cyc = c;
      running = 1'b1;
    end
    @(posedge clk);
    #1;
    running = 1'b0;

    tests = tests + 1;
    if (exp_q.size() != 0) begin
      fails = fails + 1;
      $display("FAIL drain got=%0d pending events exp=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
